// File: rtl/bus_sequencer_pkg.sv
// Shared types for the bus sequencer: state encoding, opcode classes,
// ALU codes and the per-state control-word decode.
package bus_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_R3, CLS_MUL, CLS_DIV, CLS_NOP, CLS_HALT
  } opclass_t;

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] OP_R3_LAST = 5'b01011;
  localparam logic [4:0] OP_MUL     = 5'b01111;
  localparam logic [4:0] OP_DIV     = 5'b10000;
  localparam logic [4:0] OP_HALT    = 5'b11011;

  typedef struct packed {
    logic       r_out;
    logic       zhi_out;
    logic       zlo_out;
    logic       pc_out;
    logic       mdr_out;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       ir_in;
    logic       mar_in;
    logic       mdr_in;
    logic       y_in;
    logic       z_in;
    logic       hi_in;
    logic       lo_in;
    logic       read;
    logic       inc_pc;
    logic       halted;
    logic [4:0] alu_op;
  } ctl_t;

  // Control word presented while sitting in state s; pc_in is handled outside
  // because it depends on the live memory handshake.
  function automatic ctl_t ctl_for(state_t s, opclass_t c, logic [4:0] op);
    ctl_t k;
    k = '0;
    case (s)
      S_T0: begin
        k.pc_out = 1'b1;
        k.mar_in = 1'b1;
        k.inc_pc = 1'b1;
        k.z_in   = 1'b1;
        k.alu_op = ALU_ADD;
      end
      S_T1: begin
        k.zlo_out = 1'b1;
        k.read    = 1'b1;
        k.mdr_in  = 1'b1;
      end
      S_T2: begin
        k.mdr_out = 1'b1;
        k.ir_in   = 1'b1;
      end
      S_T3: begin
        if (c == CLS_R3 || c == CLS_MUL || c == CLS_DIV) begin
          k.grb   = 1'b1;
          k.r_out = 1'b1;
          k.y_in  = 1'b1;
        end
      end
      S_T4: begin
        k.grc    = 1'b1;
        k.r_out  = 1'b1;
        k.z_in   = 1'b1;
        k.alu_op = op;
      end
      S_T5: begin
        k.zlo_out = 1'b1;
        if (c == CLS_R3) begin
          k.gra  = 1'b1;
          k.r_in = 1'b1;
        end else begin
          k.lo_in = 1'b1;
        end
      end
      S_T6: begin
        k.zhi_out = 1'b1;
        k.hi_in   = 1'b1;
      end
      S_HALT: k.halted = 1'b1;
      default: k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/opclass_decode.sv
// Maps a 5-bit opcode onto its execution class; anything unlisted is a NOP.
module opclass_decode
  import bus_sequencer_pkg::*;
(
  input  logic [4:0] opcode,
  output opclass_t   opclass
);

  always_comb begin
    opclass = CLS_NOP;
    if (opcode <= OP_R3_LAST)   opclass = CLS_R3;
    else if (opcode == OP_MUL)  opclass = CLS_MUL;
    else if (opcode == OP_DIV)  opclass = CLS_DIV;
    else if (opcode == OP_HALT) opclass = CLS_HALT;
  end

endmodule

// File: rtl/bus_sequencer.sv
// Fetch/execute control sequencer: steps T0..T6 per instruction and drives
// registered bus-source, load and control strobes.
module bus_sequencer
  import bus_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_rdy,
  output logic        r_out,
  output logic        hi_out,
  output logic        lo_out,
  output logic        zhi_out,
  output logic        zlo_out,
  output logic        pc_out,
  output logic        mdr_out,
  output logic        inport_out,
  output logic        c_out,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        r_in,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        read,
  output logic        inc_pc,
  output logic [4:0]  alu_op,
  output logic        halted
);

  state_t     state, state_nxt;
  logic [4:0] opcode, opcode_nxt;
  opclass_t   cls_nxt;
  ctl_t       ctl, ctl_nxt;
  logic       unused_ir;

  assign unused_ir = ^ir[26:0];

  // The opcode is captured as T2 hands over to T3, so T3 already decodes it.
  assign opcode_nxt = (state == S_T2) ? ir[31:27] : opcode;

  opclass_decode u_opclass_decode (
    .opcode  (opcode_nxt),
    .opclass (cls_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (run) state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   if (mem_rdy) state_nxt = S_T2;
      S_T2:   state_nxt = S_T3;
      S_T3: begin
        if (cls_nxt == CLS_NOP)       state_nxt = S_T0;
        else if (cls_nxt == CLS_HALT) state_nxt = S_HALT;
        else                          state_nxt = S_T4;
      end
      S_T4:   state_nxt = S_T5;
      S_T5:   state_nxt = (cls_nxt == CLS_R3) ? S_T0 : S_T6;
      S_T6:   state_nxt = S_T0;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
    ctl_nxt = ctl_for(state_nxt, cls_nxt, opcode_nxt);
  end

  // Outputs are registered alongside the state so they line up with it.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state  <= S_IDLE;
      opcode <= '0;
      ctl    <= '0;
    end else begin
      state  <= state_nxt;
      opcode <= opcode_nxt;
      ctl    <= ctl_nxt;
    end
  end

  // pc_in must fire only on the T1 exit cycle, which is known only from mem_rdy.
  assign pc_in = (state == S_T1) && mem_rdy;

  assign r_out      = ctl.r_out;
  assign hi_out     = 1'b0;
  assign lo_out     = 1'b0;
  assign zhi_out    = ctl.zhi_out;
  assign zlo_out    = ctl.zlo_out;
  assign pc_out     = ctl.pc_out;
  assign mdr_out    = ctl.mdr_out;
  assign inport_out = 1'b0;
  assign c_out      = 1'b0;
  assign gra        = ctl.gra;
  assign grb        = ctl.grb;
  assign grc        = ctl.grc;
  assign r_in       = ctl.r_in;
  assign ir_in      = ctl.ir_in;
  assign mar_in     = ctl.mar_in;
  assign mdr_in     = ctl.mdr_in;
  assign y_in       = ctl.y_in;
  assign z_in       = ctl.z_in;
  assign hi_in      = ctl.hi_in;
  assign lo_in      = ctl.lo_in;
  assign read       = ctl.read;
  assign inc_pc     = ctl.inc_pc;
  assign alu_op     = ctl.alu_op;
  assign halted     = ctl.halted;

endmodule

// File: tb/tb_bus_sequencer.sv
// Scoreboard bench for bus_sequencer: per-instruction expected control
// sequences are queued by the stimulus and checked by a negedge monitor.
module tb_bus_sequencer;

  logic        clock;
  logic        clear;
  logic        run;
  logic [31:0] ir;
  logic        mem_rdy;
  logic        r_out, hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out;
  logic        gra, grb, grc;
  logic        r_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in;
  logic        read, inc_pc, halted;
  logic [4:0]  alu_op;
  logic [28:0] actual;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [28:0] exp;
  } sb_t;
  sb_t expq[$];

  localparam logic [28:0] M_C_OUT   = 29'd1 << 0;
  localparam logic [28:0] M_INPORT  = 29'd1 << 1;
  localparam logic [28:0] M_MDR_OUT = 29'd1 << 2;
  localparam logic [28:0] M_PC_OUT  = 29'd1 << 3;
  localparam logic [28:0] M_ZLO_OUT = 29'd1 << 4;
  localparam logic [28:0] M_ZHI_OUT = 29'd1 << 5;
  localparam logic [28:0] M_LO_OUT  = 29'd1 << 6;
  localparam logic [28:0] M_HI_OUT  = 29'd1 << 7;
  localparam logic [28:0] M_R_OUT   = 29'd1 << 8;
  localparam logic [28:0] M_GRC     = 29'd1 << 9;
  localparam logic [28:0] M_GRB     = 29'd1 << 10;
  localparam logic [28:0] M_GRA     = 29'd1 << 11;
  localparam logic [28:0] M_LO_IN   = 29'd1 << 12;
  localparam logic [28:0] M_HI_IN   = 29'd1 << 13;
  localparam logic [28:0] M_Z_IN    = 29'd1 << 14;
  localparam logic [28:0] M_Y_IN    = 29'd1 << 15;
  localparam logic [28:0] M_MDR_IN  = 29'd1 << 16;
  localparam logic [28:0] M_MAR_IN  = 29'd1 << 17;
  localparam logic [28:0] M_IR_IN   = 29'd1 << 18;
  localparam logic [28:0] M_PC_IN   = 29'd1 << 19;
  localparam logic [28:0] M_R_IN    = 29'd1 << 20;
  localparam logic [28:0] M_INC_PC  = 29'd1 << 21;
  localparam logic [28:0] M_READ    = 29'd1 << 22;
  localparam logic [28:0] M_HALTED  = 29'd1 << 28;

  bus_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_rdy(mem_rdy),
    .r_out(r_out), .hi_out(hi_out), .lo_out(lo_out), .zhi_out(zhi_out),
    .zlo_out(zlo_out), .pc_out(pc_out), .mdr_out(mdr_out),
    .inport_out(inport_out), .c_out(c_out),
    .gra(gra), .grb(grb), .grc(grc),
    .r_in(r_in), .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in),
    .mdr_in(mdr_in), .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in),
    .read(read), .inc_pc(inc_pc), .alu_op(alu_op), .halted(halted)
  );

  assign actual = {halted, alu_op, read, inc_pc, r_in, pc_in, ir_in, mar_in,
                   mdr_in, y_in, z_in, hi_in, lo_in, gra, grb, grc, r_out,
                   hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out,
                   inport_out, c_out};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [28:0] aluField(input logic [4:0] op);
    return 29'(op) << 23;
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  task automatic checkOutput(input string name, input logic [28:0] exp);
    vectors++;
    if (actual !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, exp);
    end
  endtask

  // One stimulus window: inputs change just after the rising edge, and the
  // expected outputs for this window are queued for the monitor.
  task automatic applyStimulus(input bit r, input bit clr, input logic [31:0] instr,
                               input bit rdy, input logic [28:0] exp, input string tag);
    @(posedge clock);
    #1;
    run     = r;
    clear   = clr;
    ir      = instr;
    mem_rdy = rdy;
    expq.push_back('{tag, exp});
  endtask

  // Reference model: the expected cycle-by-cycle sequence of one instruction.
  task automatic issueInstruction(input logic [4:0] op, input int waits, input bit cut_at_t4);
    bit arith, muldiv;
    string t;
    arith  = (op <= 5'd11) || (op == 5'd15) || (op == 5'd16);
    muldiv = (op == 5'd15) || (op == 5'd16);
    t = $sformatf("op%0d", op);
    applyStimulus(rb(), 1'b1, $urandom, rb(),
                  M_PC_OUT | M_MAR_IN | M_INC_PC | M_Z_IN | aluField(5'd0), {t, "_T0"});
    for (int w = 0; w < waits; w++)
      applyStimulus(rb(), 1'b1, $urandom, 1'b0, M_ZLO_OUT | M_READ | M_MDR_IN, {t, "_T1wait"});
    applyStimulus(rb(), 1'b1, $urandom, 1'b1,
                  M_ZLO_OUT | M_READ | M_MDR_IN | M_PC_IN, {t, "_T1exit"});
    applyStimulus(rb(), 1'b1, {op, 27'($urandom)}, rb(), M_MDR_OUT | M_IR_IN, {t, "_T2"});
    applyStimulus(rb(), 1'b1, $urandom, rb(),
                  arith ? (M_GRB | M_R_OUT | M_Y_IN) : 29'd0, {t, "_T3"});
    if (!arith) return;
    applyStimulus(rb(), 1'b1, $urandom, rb(), M_GRC | M_R_OUT | M_Z_IN | aluField(op), {t, "_T4"});
    if (cut_at_t4) return;
    applyStimulus(rb(), 1'b1, $urandom, rb(),
                  muldiv ? (M_ZLO_OUT | M_LO_IN) : (M_ZLO_OUT | M_GRA | M_R_IN), {t, "_T5"});
    if (muldiv)
      applyStimulus(rb(), 1'b1, $urandom, rb(), M_ZHI_OUT | M_HI_IN, {t, "_T6"});
  endtask

  task automatic asyncClear(input string name);
    @(negedge clock);
    #2;
    clear = 1'b0;
    #1;
    checkOutput(name, 29'd0);
  endtask

  always @(negedge clock) begin
    if (expq.size() > 0) begin
      sb_t e;
      e = expq.pop_front();
      checkOutput(e.tag, e.exp);
      vectors++;
      if ($countones(actual[8:0]) > 1) begin
        miscompares++;
        $display("[TB] FAIL onehot_%s: got %0d drivers expected at most 1", e.tag,
                 $countones(actual[8:0]));
      end
    end
  end

  initial begin
    logic [4:0] op;
    int w;
    clear = 1'b1; run = 1'b0; ir = '0; mem_rdy = 1'b0;
    #1 clear = 1'b0;
    #1 checkOutput("reset_state", 29'd0);

    applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 29'd0, "hold_clear");
    applyStimulus(1'b0, 1'b1, $urandom, 1'b0, 29'd0, "idle_run0_a");
    applyStimulus(1'b0, 1'b1, $urandom, 1'b1, 29'd0, "idle_run0_b");
    applyStimulus(1'b1, 1'b1, $urandom, 1'b0, 29'd0, "idle_run1");

    issueInstruction(5'd0, 0, 1'b0);
    issueInstruction(5'd15, 0, 1'b0);
    issueInstruction(5'd1, 3, 1'b0);
    issueInstruction(5'd20, 0, 1'b0);
    issueInstruction(5'd26, 1, 1'b0);
    issueInstruction(5'd16, 0, 1'b0);
    issueInstruction(5'd11, 0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) op = ($urandom_range(0, 1) == 1) ? 5'd15 : 5'd16;
      else begin
        op = 5'($urandom);
        while (op == 5'd27) op = 5'($urandom);
      end
      w = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      issueInstruction(op, w, 1'b0);
    end

    issueInstruction(5'd0, 1, 1'b1);
    asyncClear("clear_in_T4");
    applyStimulus(1'b1, 1'b0, $urandom, 1'b1, 29'd0, "clear_held");
    applyStimulus(1'b0, 1'b1, $urandom, 1'b1, 29'd0, "post_clear_run0");
    applyStimulus(1'b1, 1'b1, $urandom, 1'b0, 29'd0, "post_clear_run1");
    issueInstruction(5'd16, 2, 1'b0);

    issueInstruction(5'd27, 1, 1'b0);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'(i % 2), 1'b1, $urandom, rb(), M_HALTED, $sformatf("halt_%0d", i));
    asyncClear("clear_in_halt");
    applyStimulus(1'b0, 1'b1, $urandom, 1'b0, 29'd0, "idle_after_halt_a");
    applyStimulus(1'b0, 1'b1, $urandom, 1'b0, 29'd0, "idle_after_halt_b");

    @(posedge clock);
    @(negedge clock);
    #1;
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
